// File: rtl/spi_master.sv
// spi_master
//   Mode-0 (CPOL=0, CPHA=0) SPI master. Each transfer is DATA_W bits
//   (only 8 is verified). A start/busy/done handshake drives it. The serial
//   clock half-period is clk_div clk cycles; clk_div = 0 is treated as 1.
//
//   Ports:
//     clk      in   system clock, rising edge
//     reset_n  in   synchronous active-low reset
//     start    in   transfer request, sampled only in IDLE
//     tx_data  in   byte to send, latched when start is accepted
//     clk_div  in   sclk half-period in clk cycles, latched when start is accepted
//     miso     in   serial data from the slave (not synchronized)
//     busy     out  high while cs_n is low
//     done     out  one-cycle pulse on transfer completion
//     rx_data  out  last received byte, updated with done
//     sclk     out  serial clock, idles low
//     cs_n     out  chip select, idles high
//     mosi     out  serial data to the slave, 0 when idle
//
//   Build option:
//     SPI_MASTER_LSB_FIRST_EN  defined   -> LSB-first shift order
//                              undefined -> MSB-first shift order (default)
//   Timing is the same in both builds.

module spi_master #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [7:0]        clk_div,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi
);

  localparam int unsigned BW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t            state;
  logic [7:0]        half_reg;
  logic [7:0]        half_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  logic [7:0]        h_eff;
  logic              phase_end;
  logic              last_bit;
  logic              tx_first_bit;
  logic [DATA_W-1:0] tx_load_shift;
  logic              tx_next_bit;
  logic [DATA_W-1:0] tx_next_shift;
  logic [DATA_W-1:0] rx_next;

  assign h_eff     = (clk_div == '0) ? 8'd1 : clk_div;
  assign phase_end = (half_cnt == '0);
  // Once all bits have been sampled, the LOW phase that follows is the trail phase.
  assign last_bit  = (bit_cnt == BW'(DATA_W));

  // The shift registers hold only the bits still to be sent. mosi itself
  // carries the bit currently on the wire.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_first_bit  = tx_data[0];
  assign tx_load_shift = {1'b0, tx_data[DATA_W-1:1]};
  assign tx_next_bit   = tx_shift[0];
  assign tx_next_shift = {1'b0, tx_shift[DATA_W-1:1]};
  assign rx_next       = {miso, rx_shift[DATA_W-1:1]};
`else
  assign tx_first_bit  = tx_data[DATA_W-1];
  assign tx_load_shift = {tx_data[DATA_W-2:0], 1'b0};
  assign tx_next_bit   = tx_shift[DATA_W-1];
  assign tx_next_shift = {tx_shift[DATA_W-2:0], 1'b0};
  assign rx_next       = {rx_shift[DATA_W-2:0], miso};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      half_reg <= 8'd1;
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LEAD;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= tx_first_bit;
            tx_shift <= tx_load_shift;
            rx_shift <= '0;
            half_reg <= h_eff;
            half_cnt <= h_eff - 8'd1;
            bit_cnt  <= '0;
          end
        end

        ST_LEAD: begin
          if (phase_end) begin
            state    <= ST_HIGH;
            sclk     <= 1'b1;
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + BW'(1);
            half_cnt <= half_reg - 8'd1;
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        ST_HIGH: begin
          if (phase_end) begin
            state    <= ST_LOW;
            sclk     <= 1'b0;
            half_cnt <= half_reg - 8'd1;
            // In the trail phase mosi keeps the last bit.
            if (!last_bit) begin
              mosi     <= tx_next_bit;
              tx_shift <= tx_next_shift;
            end
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        ST_LOW: begin
          if (phase_end) begin
            if (last_bit) begin
              state   <= ST_IDLE;
              cs_n    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              mosi    <= 1'b0;
              rx_data <= rx_shift;
              bit_cnt <= '0;
            end else begin
              state    <= ST_HIGH;
              sclk     <= 1'b1;
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + BW'(1);
              half_cnt <= half_reg - 8'd1;
            end
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master
//   Directed self-checking bench for spi_master. A negedge monitor measures
//   cs_n low/high run lengths, sclk high/low phase lengths, counts sclk rises
//   and done pulses, and records the mosi bit seen at each sclk rise.
//   Expected byte order follows SPI_MASTER_LSB_FIRST_EN.

module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] clk_div;
  logic       miso;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic       cs_n;
  logic       mosi;

  logic       loop_en;
  logic       miso_val;

  assign miso = loop_en ? mosi : miso_val;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .tx_data (tx_data),
    .clk_div (clk_div),
    .miso    (miso),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi)
  );

  // Monitor state (written only by the monitor process).
  int          exp_h       = 1;
  int          cs_low_run  = 0;
  int          cs_high_run = 0;
  int          cs_low_last = 0;
  int          cs_gap_last = 0;
  int          hi_run      = 0;
  int          lo_run      = 0;
  int          hi_bad      = 0;
  int          lo_bad      = 0;
  int          rises       = 0;
  int          done_cnt    = 0;
  logic [15:0] mosi_hist   = '0;
  logic        prev_cs     = 1'b1;
  logic        prev_sclk   = 1'b0;

  always @(negedge clk) begin
    if (cs_n) begin
      if (!prev_cs) begin
        cs_low_last = cs_low_run;
        cs_high_run = 0;
        if (lo_run != exp_h) lo_bad++;
      end
      cs_high_run++;
    end else begin
      if (prev_cs) begin
        cs_gap_last = cs_high_run;
        cs_low_run  = 0;
        lo_run      = 0;
      end
      cs_low_run++;
    end

    if (sclk) begin
      if (!prev_sclk) begin
        rises++;
        mosi_hist = {mosi_hist[14:0], mosi};
        if (lo_run != exp_h) lo_bad++;
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_sclk) begin
        if (hi_run != exp_h) hi_bad++;
        lo_run = 0;
      end
      if (!cs_n) lo_run++;
    end

    if (done) done_cnt++;
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Order in which the byte's bits appear on mosi, packed first-bit-in-MSB.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
`else
    return b;
`endif
  endfunction

  function automatic logic first_bit(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+#1 with the DUT idle; returns at E0+#1.
  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] div);
    start   = 1'b1;
    tx_data = tx;
    clk_div = div;
    tick(1);
    start = 1'b0;
    check("busy_at_E0", busy, 1);
    check("cs_n_at_E0", cs_n, 0);
    check("sclk_at_E0", sclk, 0);
    check("mosi_first", mosi, first_bit(tx));
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick(1);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  int r0, h0, l0, d0;

  task automatic snap();
    r0 = rises;
    h0 = hi_bad;
    l0 = lo_bad;
    d0 = done_cnt;
  endtask

  task automatic one_xfer(input string name, input logic [7:0] tx, input logic [7:0] div,
                          input logic [7:0] rx_exp, input int h);
    exp_h = h;
    snap();
    start_xfer(tx, div);
    wait_done(40 * h + 20);
    check({name, "_rx"}, rx_data, rx_exp);
    check({name, "_busy_at_done"}, busy, 0);
    tick(3);
    check({name, "_done_width"}, done, 0);
    check({name, "_cs_low_len"}, cs_low_last, 17 * h);
    check({name, "_sclk_rises"}, rises - r0, 8);
    check({name, "_hi_phase_bad"}, hi_bad - h0, 0);
    check({name, "_lo_phase_bad"}, lo_bad - l0, 0);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_mosi_bits"}, mosi_hist[7:0], wire_order(tx));
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    tx_data  = '0;
    clk_div  = '0;
    loop_en  = 1'b1;
    miso_val = 1'b0;
    tick(3);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 8'h00);
    reset_n = 1'b1;
    tick(2);

    // Loopback, H=2.
    one_xfer("t1_a5", 8'hA5, 8'd2, 8'hA5, 2);

    // clk_div=0 acts as H=1, miso tied high.
    loop_en  = 1'b0;
    miso_val = 1'b1;
    one_xfer("t2_3c", 8'h3C, 8'd0, 8'hFF, 1);
    loop_en  = 1'b1;

    // start, tx_data and clk_div changes mid-transfer are ignored.
    exp_h = 1;
    snap();
    start_xfer(8'h5A, 8'd1);
    tick(5);
    start   = 1'b1;
    tx_data = 8'h11;
    clk_div = 8'd9;
    tick(1);
    start = 1'b0;
    wait_done(60);
    check("t3_rx", rx_data, 8'h5A);
    tick(40);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_no_requeue", cs_n, 1);
    check("t3_hi_phase_bad", hi_bad - h0, 0);
    check("t3_mosi_bits", mosi_hist[7:0], wire_order(8'h5A));

    // Back-to-back with start held high.
    exp_h = 1;
    snap();
    start_xfer(8'h81, 8'd1);
    start = 1'b1;
    wait_done(60);
    check("t4_rx_first", rx_data, 8'h81);
    tx_data = 8'h7E;
    tick(1);
    start = 1'b0;
    check("t4_second_accept", cs_n, 0);
    wait_done(60);
    check("t4_rx_second", rx_data, 8'h7E);
    tick(3);
    check("t4_cs_gap", cs_gap_last, 1);
    check("t4_done_count", done_cnt - d0, 2);
    check("t4_sclk_rises", rises - r0, 16);
    check("t4_mosi_bits", mosi_hist, {wire_order(8'h81), wire_order(8'h7E)});

    // Reset during the 4th HIGH phase (H=2: entered at E0+14).
    exp_h = 2;
    start_xfer(8'hC3, 8'd2);
    tick(14);
    check("t5_in_4th_high", sclk, 1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("t5_cs_n", cs_n, 1);
    check("t5_sclk", sclk, 0);
    check("t5_busy", busy, 0);
    check("t5_mosi", mosi, 0);
    check("t5_done", done, 0);
    check("t5_rx_cleared", rx_data, 8'h00);
    tick(2);
    snap();
    tick(40);
    check("t5_no_done", done_cnt - d0, 0);
    one_xfer("t5_after", 8'h96, 8'd3, 8'h96, 3);

    // Single set bit shows the shift order.
    one_xfer("t6_01", 8'h01, 8'd1, 8'h01, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that initiates 8-bit, mode-0 (CPOL=0, CPHA=0) transfers toward the SPI slave peripherals in this design. It generates `sclk`, `cs_n` and `mosi`, and captures `miso` into a receive register. A simple start/busy/done handshake drives it from a local controller or register bank. The serial clock is derived from `clk` by a programmable half-period divider.

## Interface
Parameters:
- `DATA_W`, 8: transfer width in bits. Only 8 is verified.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request a transfer; sampled only in IDLE
- `tx_data`  in  8  byte to shift out; latched when `start` is accepted
- `clk_div`  in  8  half-period of `sclk` in `clk` cycles; latched when `start` is accepted; 0 is treated as 1
- `miso`  in  1  serial data from slave
- `busy`  out  1  high while a transfer is in progress (`cs_n`=0)
- `done`  out  1  one-cycle pulse when a transfer completes
- `rx_data`  out  8  last received byte; holds until the next `done`
- `sclk`  out  1  serial clock, idles low
- `cs_n`  out  1  chip select, active-low, idles high
- `mosi`  out  1  serial data to slave

## Operation
- All outputs are registered. Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0x00. State returns to IDLE.
- H = latched `clk_div`, or 1 if `clk_div`=0. A half-period counter counts H cycles per phase.
- States:
  - IDLE: `cs_n`=1, `sclk`=0. On `start`=1: latch `tx_data` into the shift register and latch H. Go to LEAD.
  - LEAD: `cs_n`=0, `busy`=1, `mosi`=bit 7, `sclk`=0. Stay H cycles, then go to HIGH.
  - HIGH: `sclk`=1. On the clock edge that raises `sclk`, sample `miso` into the receive shift register. Stay H cycles, then go to LOW. The bit counter increments.
  - LOW: `sclk`=0. On the edge that lowers `sclk`, `mosi` advances to the next bit. Stay H cycles, then go to HIGH.
  - After the 8th HIGH phase, the following LOW phase is the trail phase. `mosi` holds its last value. After H cycles, go to IDLE.
  - On the IDLE-entry edge: `cs_n`=1, `busy`=0, `done`=1 for one cycle, and `rx_data` takes the assembled byte.
- Shift order is MSB first: the first bit out is `tx_data[7]`, and the first bit received lands in `rx_data[7]`.
- `start` while `busy`=1 is ignored and not queued.
- `tx_data` and `clk_div` changes during a transfer have no effect.
- `mosi` is 0 in IDLE.

## Timing
- Start is accepted at edge E0. `cs_n` falls, `busy` rises and `mosi` is valid at E0.
- `sclk` rising edges occur at E0 + H + 2kH, for k = 0..7.
- `cs_n` is low for exactly 17·H cycles. `done` and `rx_data` update at E0 + 17H.
- Back-to-back: `start`=1 during the `done` cycle is accepted. `cs_n` is then high for exactly one cycle between transfers.
- Synchronous reset mid-transfer: at the next edge, all outputs return to reset values. No `done` pulse is issued and `rx_data` clears to 0x00.
- `miso` is assumed stable around the `sclk` rising edge. This block does not synchronize it.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - Defined: shift order is LSB first. The first bit out is `tx_data[0]`, and the first bit received lands in `rx_data[0]`.
  - Undefined (default): MSB first, as in Operation.
- All timing is identical in both builds.

## Test plan
- `clk_div`=2, `tx_data`=0xA5, `miso` looped back from `mosi` -> `cs_n` low 34 cycles, 8 `sclk` pulses of 2 high / 2 low cycles, `done` one pulse, `rx_data`=0xA5.
- `clk_div`=0, `tx_data`=0x3C, `miso` tied 1 -> H=1, `cs_n` low 17 cycles, `mosi` bit sequence 0,0,1,1,1,1,0,0, `rx_data`=0xFF.
- `start` pulsed again mid-transfer with `tx_data`=0x11 -> ignored; the original byte completes, and only one `done` is seen.
- `start` held high through `done`, with `tx_data`=0x81 then 0x7E -> two transfers, `cs_n` high exactly 1 cycle between them, and loopback `rx_data` of 0x81 then 0x7E.
- `reset_n`=0 for one cycle during the 4th HIGH phase -> next edge `cs_n`=1, `sclk`=0, `busy`=0, `rx_data`=0x00, no `done`. A subsequent transfer completes normally.
- `SPI_MASTER_LSB_FIRST_EN` build, `tx_data`=0x01, loopback -> `mosi` first bit 1, `rx_data`=0x01.
